// File: rtl/seq_div_16x8.sv
// Restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock, valid/ready on both sides.
// Latency 16 steps after accept (1 for zero divisor, 8 with SEQ_DIV_EARLY_TERM_EN when the quotient fits in a byte); output holds under back-pressure.
module seq_div_16x8 #(
   parameter int N_W = 16,
   parameter int D_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_W-1:0] dividend,
   input  logic [D_W-1:0] divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N_W-1:0] quotient,
   output logic [D_W-1:0] remainder,
   output logic           div_by_zero
);

   localparam int C_W = $clog2(N_W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t         state_q, state_d;
   logic [C_W-1:0] cnt_q, cnt_d;
   logic [D_W:0]   prem_q, prem_d;
   logic [N_W-1:0] dvd_q, dvd_d;
   logic [D_W-1:0] dvs_q, dvs_d;
   logic [N_W-1:0] quo_q, quo_d;
   logic [D_W-1:0] rem_q, rem_d;
   logic           dbz_q, dbz_d;

   logic [D_W+1:0] trial;
   logic           ge;
   logic [D_W:0]   prem_nxt;

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prem_d   = prem_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      dbz_d    = dbz_q;
      trial    = {1'b0, prem_q, dvd_q[N_W-1]};
      ge       = (trial >= {2'b00, dvs_q});
      prem_nxt = ge ? (D_W+1)'(trial - {2'b00, dvs_q}) : (D_W+1)'(trial);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               dbz_d   = 1'b0;
               prem_d  = '0;
               state_d = CALC;
               if (divisor == '0) begin
                  // Zero divisor spends a single pass through CALC with no arithmetic.
                  quo_d = '1;
                  rem_d = dividend[D_W-1:0];
                  dbz_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  quo_d = '0;
                  cnt_d = C_W'(N_W-1);
`ifdef SEQ_DIV_EARLY_TERM_EN
                  if (dividend[N_W-1:D_W] < divisor) begin
                     prem_d = {1'b0, dividend[N_W-1:D_W]};
                     dvd_d  = dividend << D_W;
                     cnt_d  = C_W'(D_W-1);
                  end
`endif
               end
            end
         end
         CALC: begin
            if (dbz_q) begin
               state_d = DONE;
            end else begin
               dvd_d  = dvd_q << 1;
               prem_d = prem_nxt;
               quo_d  = {quo_q[N_W-2:0], ge};
               if (cnt_q == '0) begin
                  rem_d   = prem_nxt[D_W-1:0];
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

endmodule

// File: tb/tb_seq_div_16x8.sv
// Directed and randomized checks of seq_div_16x8 against hand values and a / % golden model.
// Build with +define+SEQ_DIV_EARLY_TERM_EN to check the shortened latency.
module tb_seq_div_16x8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_div_16x8 dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [15:0] n, input logic [7:0] d, input int hold, input bit noisy);
      logic [15:0] eq;
      logic [7:0]  er;
      logic        ed;
      int          el;
      int          lat;
      int          w;
      if (d == 8'd0) begin
         eq = 16'hFFFF; er = n[7:0]; ed = 1'b1; el = 1;
      end else begin
         eq = n / d; er = 8'(n % d); ed = 1'b0; el = 16;
`ifdef SEQ_DIV_EARLY_TERM_EN
         if (n[15:8] < d) el = 8;
`endif
      end
      w = 0;
      while (!in_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      chk("in_ready_idle", in_ready, 1);
      dividend = n; divisor = d; in_valid = 1'b1; out_ready = (hold == 0);
      @(posedge clk); #1;
      chk("in_ready_busy", in_ready, 0);
      if (noisy) begin
         dividend = ~n; divisor = d + 8'd1;
      end else begin
         in_valid = 1'b0;
      end
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!out_valid && lat < 40);
      in_valid = 1'b0;
      chk("latency", lat, el);
      chk("out_valid", out_valid, 1);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_by_zero", div_by_zero, ed);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_quotient", quotient, eq);
         chk("hold_remainder", remainder, er);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("valid_drop", out_valid, 0);
      chk("back_idle", in_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rn;
      logic [7:0]  rd;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'd1000, 8'd7, 0, 1'b0);
      run_op(16'hFFFF, 8'hFF, 0, 1'b0);
      run_op(16'hFFFF, 8'd1, 0, 1'b0);
      run_op(16'd100, 8'd0, 0, 1'b0);
      run_op(16'd50000, 8'd200, 10, 1'b1);

      // Reset during step 5 of 1234/3, then rerun the same operands.
      dividend = 16'd1234; divisor = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         chk("pre_rst_no_valid", out_valid, 0);
      end
      rst_n = 1'b0; #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_quotient", quotient, 0);
      chk("mid_rst_remainder", remainder, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'd1234, 8'd3, 0, 1'b0);

      for (int k = 0; k < 1200; k++) begin
         rn = 16'($urandom);
         case ($urandom_range(0, 7))
            0: rd = 8'd0;
            1: rd = 8'd1;
            2: rd = 8'd255;
            default: rd = 8'($urandom);
         endcase
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         run_op(rn, rd, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
